// File: rtl/psum_drain.sv
// psum_drain -- collects one result per PE lane and drains the completed row
// as a valid/ready stream, one lane per cycle, lane 0 first.
//
// Each lane has its own capture register and full flag, so lanes may arrive
// with systolic skew. Once every lane is full the FSM enters DRAIN on the next
// edge and presents capture[ptr] until it is accepted. A lane being popped can
// accept a new result in the same cycle (capture wins). A result that arrives
// for a lane that is already full and not being popped is dropped, and the
// sticky OVERRUN flag is raised.
//
// Optional feature: define PSUM_DRAIN_SAT8_EN to saturate OUT_DATA to 255
// (zero-extended to C_W). Capture registers stay C_W wide in both builds.
//
// Ports:
//   CLK         clock, rising edge
//   RST         asynchronous active-low reset
//   C_in        packed PE results, lane i at [i*C_W +: C_W]
//   C_valid_in  per-lane result-valid pulses
//   OUT_DATA    result being drained
//   OUT_LANE    lane index of OUT_DATA
//   OUT_VALID   downstream valid
//   OUT_READY   downstream ready
//   OUT_LAST    final lane of the row
//   BUSY        high while draining
//   OVERRUN     sticky drop-on-full error flag
//   OVR_CLR     synchronous clear for OVERRUN (a same-cycle new overrun wins)
module psum_drain #(
  parameter int unsigned N_LANE = 4,
  parameter int unsigned C_W    = 19
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [N_LANE*C_W-1:0]     C_in,
  input  logic [N_LANE-1:0]         C_valid_in,
  output logic [C_W-1:0]            OUT_DATA,
  output logic [$clog2(N_LANE)-1:0] OUT_LANE,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic                      OUT_LAST,
  output logic                      BUSY,
  output logic                      OVERRUN,
  input  logic                      OVR_CLR
);

  localparam int unsigned LW = $clog2(N_LANE);

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   ptr_q, ptr_d;
  logic [N_LANE-1:0] full_q, full_d;
  logic [C_W-1:0]  cap_q [N_LANE];
  logic [C_W-1:0]  cap_d [N_LANE];
  logic            overrun_q, overrun_d;

  logic [N_LANE-1:0] pop;
  logic [N_LANE-1:0] ovr_set;
  logic            xfer;
  logic            at_last;
  logic [C_W-1:0]  sel_data;
  logic [C_W-1:0]  out_data_val;

  assign at_last = (ptr_q == LW'(N_LANE - 1));
  assign xfer    = (state_q == StDrain) && OUT_READY;

  // Per-lane capture / pop / overrun detection
  always_comb begin
    pop     = '0;
    ovr_set = '0;
    full_d  = full_q;
    cap_d   = cap_q;
    for (int i = 0; i < N_LANE; i++) begin
      pop[i] = xfer && (ptr_q == LW'(i));
      if (C_valid_in[i]) begin
        // A lane being popped this cycle is free to take the new value.
        if (!full_q[i] || pop[i]) begin
          cap_d[i]  = C_in[i*C_W +: C_W];
          full_d[i] = 1'b1;
        end else begin
          ovr_set[i] = 1'b1;
        end
      end else if (pop[i]) begin
        full_d[i] = 1'b0;
      end
    end
  end

  // Set has priority over clear
  always_comb begin
    overrun_d = overrun_q;
    if (|ovr_set) begin
      overrun_d = 1'b1;
    end else if (OVR_CLR) begin
      overrun_d = 1'b0;
    end
  end

  // FSM: state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (&full_q) begin
          state_d = StDrain;
          ptr_d   = '0;
        end
      end
      StDrain: begin
        if (OUT_READY) begin
          if (at_last) begin
            state_d = StIdle;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        ptr_d   = '0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      full_q    <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N_LANE; i++) begin
        cap_q[i] <= '0;
      end
    end else begin
      full_q    <= full_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < N_LANE; i++) begin
        cap_q[i] <= cap_d[i];
      end
    end
  end

  // Read mux for the current drain lane
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_LANE; i++) begin
      if (ptr_q == LW'(i)) begin
        sel_data = cap_q[i];
      end
    end
  end

`ifdef PSUM_DRAIN_SAT8_EN
  assign out_data_val = (sel_data > C_W'(255)) ? C_W'(255) : sel_data;
`else
  assign out_data_val = sel_data;
`endif

  // FSM: outputs
  always_comb begin
    OUT_VALID = 1'b0;
    OUT_LAST  = 1'b0;
    BUSY      = 1'b0;
    OUT_DATA  = '0;
    OUT_LANE  = ptr_q;
    unique case (state_q)
      StDrain: begin
        OUT_VALID = 1'b1;
        BUSY      = 1'b1;
        OUT_LAST  = at_last;
        OUT_DATA  = out_data_val;
      end
      default: begin
        OUT_VALID = 1'b0;
      end
    endcase
  end

  assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_psum_drain.sv
module tb_psum_drain;

  localparam int N  = 4;
  localparam int CW = 19;

  logic              CLK = 1'b0;
  logic              RST;
  logic [N*CW-1:0]   c_in;
  logic [N-1:0]      c_valid_in;
  logic [CW-1:0]     out_data;
  logic [$clog2(N)-1:0] out_lane;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              overrun;
  logic              ovr_clr;

  psum_drain #(.N_LANE(N), .C_W(CW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .C_in       (c_in),
    .C_valid_in (c_valid_in),
    .OUT_DATA   (out_data),
    .OUT_LANE   (out_lane),
    .OUT_VALID  (out_valid),
    .OUT_READY  (out_ready),
    .OUT_LAST   (out_last),
    .BUSY       (busy),
    .OVERRUN    (overrun),
    .OVR_CLR    (ovr_clr)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Drive values for the next edge
  logic [N-1:0]  d_vin;
  logic [CW-1:0] d_val [N];
  logic          d_ready;
  logic          d_clr;

  // Reference model: per-lane slot contents and the lane being offered (-1 = none)
  logic [CW-1:0] m_val [N];
  bit            m_full [N];
  int            m_drain;
  bit            m_ovr;

  typedef struct {
    logic [N-1:0] vin;
    int unsigned  val;
    bit           exp_valid;
    int unsigned  exp_data;
    int unsigned  exp_lane;
    bit           exp_last;
    bit           exp_busy;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
`ifdef PSUM_DRAIN_SAT8_EN
    return (v > 255) ? CW'(255) : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_val[i]  = '0;
      m_full[i] = 0;
    end
    m_drain = -1;
    m_ovr   = 0;
  endtask

  task automatic model_step();
    bit all_full;
    bit new_ovr;
    int pop_lane;
    all_full = 1;
    new_ovr  = 0;
    for (int i = 0; i < N; i++) if (!m_full[i]) all_full = 0;
    pop_lane = (m_drain >= 0 && d_ready) ? m_drain : -1;
    for (int i = 0; i < N; i++) begin
      if (d_vin[i]) begin
        if (!m_full[i] || i == pop_lane) begin
          m_val[i]  = d_val[i];
          m_full[i] = 1;
        end else begin
          new_ovr = 1;
        end
      end else if (i == pop_lane) begin
        m_full[i] = 0;
      end
    end
    if (new_ovr) m_ovr = 1;
    else if (d_clr) m_ovr = 0;
    if (m_drain < 0) begin
      if (all_full) m_drain = 0;
    end else if (d_ready) begin
      m_drain = (m_drain == N - 1) ? -1 : m_drain + 1;
    end
  endtask

  task automatic model_check();
    bit v;
    v = (m_drain >= 0);
    chk("valid",   out_valid, v);
    chk("busy",    busy, v);
    chk("last",    out_last, v && (m_drain == N - 1));
    chk("lane",    out_lane, v ? m_drain : 0);
    chk("data",    out_data, v ? sat(m_val[m_drain]) : 0);
    chk("overrun", overrun, m_ovr);
  endtask

  // Drive, clock one edge, advance the model, compare 1 time unit later
  task automatic cyc();
    c_valid_in = d_vin;
    out_ready  = d_ready;
    ovr_clr    = d_clr;
    for (int i = 0; i < N; i++) c_in[i*CW +: CW] = d_val[i];
    @(posedge CLK);
    model_step();
    #1;
    model_check();
  endtask

  task automatic quiet();
    d_vin   = '0;
    d_ready = 1'b1;
    d_clr   = 1'b0;
  endtask

  task automatic load4(input int unsigned a, input int unsigned b,
                       input int unsigned c, input int unsigned d);
    d_val[0] = CW'(a);
    d_val[1] = CW'(b);
    d_val[2] = CW'(c);
    d_val[3] = CW'(d);
  endtask

  initial begin
    // Basic row: lanes arrive on consecutive edges, drain with ready held high
    tbl[0] = '{4'b0001, 10, 0, 0,  0, 0, 0};
    tbl[1] = '{4'b0010, 20, 0, 0,  0, 0, 0};
    tbl[2] = '{4'b0100, 30, 0, 0,  0, 0, 0};
    tbl[3] = '{4'b1000, 40, 0, 0,  0, 0, 0};
    tbl[4] = '{4'b0000,  0, 1, 10, 0, 0, 1};
    tbl[5] = '{4'b0000,  0, 1, 20, 1, 0, 1};
    tbl[6] = '{4'b0000,  0, 1, 30, 2, 0, 1};
    tbl[7] = '{4'b0000,  0, 1, 40, 3, 1, 1};
    tbl[8] = '{4'b0000,  0, 0, 0,  0, 0, 0};

    RST        = 1'b0;
    c_in       = '0;
    c_valid_in = '0;
    out_ready  = 1'b0;
    ovr_clr    = 1'b0;
    quiet();
    load4(0, 0, 0, 0);
    model_reset();

    // Reset state
    #12;
    chk("rst_valid",   out_valid, 0);
    chk("rst_last",    out_last, 0);
    chk("rst_busy",    busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_data",    out_data, 0);
    chk("rst_lane",    out_lane, 0);
    #1 RST = 1'b1;

    // Table-driven basic row; first capture happens on the first edge after release
    for (int k = 0; k < 9; k++) begin
      quiet();
      d_vin = tbl[k].vin;
      load4(tbl[k].val, tbl[k].val, tbl[k].val, tbl[k].val);
      cyc();
      chk("tbl_valid", out_valid, tbl[k].exp_valid);
      chk("tbl_data",  out_data,  tbl[k].exp_data);
      chk("tbl_lane",  out_lane,  tbl[k].exp_lane);
      chk("tbl_last",  out_last,  tbl[k].exp_last);
      chk("tbl_busy",  busy,      tbl[k].exp_busy);
    end

    // Back-pressure: first lane held stable for three cycles
    quiet();
    load4(10, 20, 30, 40);
    for (int i = 0; i < N; i++) begin
      d_vin = 4'(1 << i);
      cyc();
    end
    quiet();
    d_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("hold_valid", out_valid, 1);
      chk("hold_data",  out_data, 10);
      chk("hold_lane",  out_lane, 0);
    end
    d_ready = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    chk("hold_done_busy", busy, 0);

    // Overrun: lane 2 gets 5 then 7 before the row is complete
    quiet();
    load4(0, 0, 5, 0);
    d_vin = 4'b0100;
    cyc();
    chk("ovr_pre", overrun, 0);
    load4(0, 0, 7, 0);
    cyc();
    chk("ovr_set", overrun, 1);
    load4(11, 12, 0, 13);
    d_vin = 4'b1011;
    cyc();
    quiet();
    cyc();
    cyc();
    cyc();
    chk("ovr_lane2_lane", out_lane, 2);
    chk("ovr_lane2_data", out_data, 5);
    cyc();
    cyc();
    chk("ovr_sticky", overrun, 1);
    d_clr = 1'b1;
    cyc();
    chk("ovr_clr", overrun, 0);

    // Pop and capture on the same lane: no overrun, value kept for the next row
    quiet();
    load4(1, 2, 3, 4);
    d_vin = 4'b1111;
    cyc();
    quiet();
    cyc();
    chk("pc_lane0", out_lane, 0);
    load4(99, 0, 0, 0);
    d_vin = 4'b0001;
    cyc();
    chk("pc_no_ovr", overrun, 0);
    quiet();
    cyc();
    cyc();
    cyc();
    chk("pc_idle", out_valid, 0);
    load4(0, 21, 22, 23);
    d_vin = 4'b1110;
    cyc();
    quiet();
    cyc();
    chk("pc_next_row_data", out_data, 99);
    chk("pc_next_row_lane", out_lane, 0);
    for (int k = 0; k < 4; k++) cyc();

    // Reset mid-drain: partial row discarded, next row drains cleanly
    quiet();
    load4(5, 6, 7, 8);
    d_vin = 4'b1111;
    cyc();
    quiet();
    cyc();
    cyc();
    cyc();
    chk("mid_lane", out_lane, 2);
    RST = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy",  busy, 0);
    chk("mid_rst_data",  out_data, 0);
    model_reset();
    #2 RST = 1'b1;
    load4(1, 2, 3, 4);
    d_vin = 4'b1111;
    cyc();
    quiet();
    cyc();
    for (int k = 0; k < N; k++) begin
      chk("rst_row_data", out_data, k + 1);
      chk("rst_row_lane", out_lane, k);
      cyc();
    end
    chk("rst_row_done", out_valid, 0);

    // Saturation option
    quiet();
    load4(300, 1, 1, 1);
    d_vin = 4'b1111;
    cyc();
    quiet();
    cyc();
`ifdef PSUM_DRAIN_SAT8_EN
    chk("sat_data", out_data, 255);
`else
    chk("sat_data", out_data, 300);
`endif
    for (int k = 0; k < 4; k++) cyc();

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        d_vin[i] = ($urandom_range(0, 99) < 35);
        d_val[i] = ($urandom_range(0, 3) == 0) ? CW'($urandom) : CW'($urandom_range(0, 400));
      end
      d_ready = ($urandom_range(0, 99) < 70);
      d_clr   = ($urandom_range(0, 99) < 5);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psum_drain.md
PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 The block SHALL have parameter N_LANE, default 4, meaning the number of PE result lanes (one per PE row/column), legal range 2..16.
REQ-002 The block SHALL have parameter C_W, default 19, meaning the width of one PE accumulator result.
REQ-003 Port CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port RST  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port C_in  input  N_LANE*C_W  SHALL carry packed PE results; lane i occupies bits [i*C_W +: C_W].
REQ-006 Port C_valid_in  input  N_LANE  SHALL be the per-lane result-valid pulse from each PE.
REQ-007 Port OUT_DATA  output  C_W  SHALL carry the result being drained.
REQ-008 Port OUT_LANE  output  clog2(N_LANE)  SHALL carry the lane index of OUT_DATA.
REQ-009 Port OUT_VALID  output  1  SHALL be the downstream valid.
REQ-010 Port OUT_READY  input  1  SHALL be the downstream ready.
REQ-011 Port OUT_LAST  output  1  SHALL mark the final lane of a drained row.
REQ-012 Port BUSY  output  1  SHALL be high while the FSM is in DRAIN.
REQ-013 Port OVERRUN  output  1  SHALL be a sticky error flag.
REQ-014 Port OVR_CLR  input  1  SHALL be a synchronous clear for OVERRUN.

Function
REQ-015 Each lane SHALL have a C_W capture register and a full flag; C_valid_in[i]=1 with full[i]=0 (or full[i] being popped this cycle) SHALL load C_in lane i and set full[i].
REQ-016 Lanes SHALL capture independently, tolerating the systolic skew of up to N_LANE-1 cycles between lanes.
REQ-017 The FSM SHALL have states IDLE and DRAIN; IDLE->DRAIN when all full flags are 1, lane pointer set to 0.
REQ-018 In DRAIN, OUT_VALID SHALL be 1, OUT_DATA = capture[ptr], OUT_LANE = ptr, OUT_LAST = (ptr == N_LANE-1); all other states OUT_VALID=0, OUT_LAST=0.
REQ-019 A transfer SHALL occur when OUT_VALID and OUT_READY are both 1: full[ptr] cleared, ptr incremented; transfer with OUT_LAST=1 SHALL return FSM to IDLE, ptr to 0.
REQ-020 OUT_DATA, OUT_LANE, OUT_LAST SHALL remain stable while OUT_VALID=1 and OUT_READY=0; OUT_VALID SHALL not drop without a transfer.
REQ-021 Latency: capture of the last-missing lane at edge t SHALL give OUT_VALID=1 after edge t+1 (registered FSM); with OUT_READY held 1, one lane SHALL drain per cycle, N_LANE cycles per row.
REQ-022 Simultaneous pop and capture on the same lane SHALL keep full=1 with the new value (capture wins).
REQ-023 C_valid_in[i]=1 while full[i]=1 and lane i not popped that cycle SHALL drop the new value, keep the old one, and set OVERRUN.
REQ-024 OVERRUN SHALL clear on OVR_CLR=1 unless a new overrun occurs the same cycle (set wins).
REQ-025 Results SHALL be treated as unsigned; no arithmetic other than REQ-030 SHALL be applied.

Reset
REQ-026 RST=0 SHALL asynchronously force FSM=IDLE, ptr=0, all full flags=0, capture registers=0, OVERRUN=0.
REQ-027 Reset outputs SHALL be OUT_VALID=0, OUT_LAST=0, BUSY=0, OVERRUN=0, OUT_DATA=0, OUT_LANE=0.
REQ-028 Reset asserted mid-DRAIN SHALL discard the partial row; no lane SHALL be re-emitted after release.
REQ-029 After RST release the block SHALL accept captures on the first rising edge.

Configuration
REQ-030 With macro PSUM_DRAIN_SAT8_EN defined, OUT_DATA SHALL be min(capture[ptr], 255) zero-extended to C_W; undefined, OUT_DATA SHALL be capture[ptr] unmodified; capture registers SHALL be C_W wide in both cases.

Verification
REQ-031 N_LANE=4, lanes valid on cycles 0,1,2,3 with values 10,20,30,40, OUT_READY=1 -> OUT_VALID from cycle 4, data 10,20,30,40, lanes 0..3, OUT_LAST only with 40, BUSY low at cycle 8.
REQ-032 Same row, OUT_READY=0 for 3 cycles after OUT_VALID rises -> OUT_DATA=10, OUT_LANE=0 held stable 3 cycles, then drains normally.
REQ-033 Lane 2 pulses 5 then 7 before drain of row starts -> OVERRUN=1, lane 2 emits 5; OVR_CLR pulse -> OVERRUN=0.
REQ-034 Lane 0 new value 99 on the cycle lane 0 transfers -> no OVERRUN, 99 captured and emitted in the next row.
REQ-035 RST=0 after lane 1 transferred -> OUT_VALID=0 immediately; after release, new row 1,2,3,4 drains lanes 0..3 correctly.
REQ-036 Value 300 on lane 0: with PSUM_DRAIN_SAT8_EN -> OUT_DATA=255; without -> OUT_DATA=300.
